sd_block_reader: RTL and testbench

Sequencer for the simulation SD-card helper. Accepts block-read requests (start sector, block count), issues one address-set pulse, then streams read strobes into the helper, captures each returned 32-bit word and delivers it on a valid/ready stream with a last marker. Sits between the SD MMIO front end and the SD card helper; the helper auto-increments after every read, so one address-set is issued per request.

---
 rtl/sd_ctrl_pkg.sv | 21 ++
 rtl/sd_word_fifo.sv | 53 +++++
 rtl/sd_block_reader.sv | 122 ++++++++++++
 tb/tb_sd_block_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the SD block-read sequencer.
package sd_ctrl_pkg;

  localparam int unsigned SD_SECTOR_SHIFT = 9;
  localparam int unsigned SD_WORD_W       = 32;
  localparam int unsigned SD_ADDR_W       = 32;
  localparam int unsigned SD_REMAIN_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETADDR,
    ST_STREAM,
    ST_DRAIN
  } sd_state_t;

  // Sector number to helper byte address; upper sector bits fall off the top.
  function automatic logic [SD_ADDR_W-1:0] sector_to_addr(input logic [31:0] sector);
    return {sector[SD_ADDR_W-SD_SECTOR_SHIFT-1:0], {SD_SECTOR_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/sd_word_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of two).
module sd_word_fifo
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SD_WORD_W + 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // A push into a full FIFO is only legal when the same cycle pops.
  assert property (@(posedge clock) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/sd_block_reader.sv
// Block-read sequencer: one address-set per request, flow-controlled read strobes, buffered word stream.
module sd_block_reader
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 128,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_sector,
  input  logic [7:0]             req_count,
  output logic                   sd_set_addr,
  output logic [SD_ADDR_W-1:0]   sd_addr,
  output logic                   sd_ren,
  input  logic [SD_WORD_W-1:0]   sd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SD_WORD_W-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  sd_state_t              state;
  logic [SD_REMAIN_W-1:0] remaining;
  logic                   ren_last;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic [SD_WORD_W:0]     fifo_head;
  logic [OW-1:0]          occupancy;
  logic                   pop;
  logic                   issue;
  logic                   last_issue;
  logic                   drained;
  logic                   unused_sector;

  assign unused_sector = ^req_sector[31:SD_ADDR_W-SD_SECTOR_SHIFT];

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head[SD_WORD_W-1:0] : '0;
  assign out_last  = out_valid && fifo_head[SD_WORD_W];
  assign pop       = out_valid && out_ready;

  // sd_ren doubles as the inflight flag: its word lands in the FIFO at the end of this cycle.
  assign occupancy  = {1'b0, fifo_count} + OW'(sd_ren);
  assign issue      = ((state == ST_SETADDR) || (state == ST_STREAM)) &&
                      (remaining != '0) && (occupancy < OW'(FIFO_DEPTH));
  assign last_issue = issue && (remaining == SD_REMAIN_W'(1));
  // Looks one edge ahead so done rises the cycle after the final pop.
  assign drained    = !sd_ren && (fifo_empty || ((fifo_count == CW'(1)) && pop));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      sd_set_addr <= 1'b0;
      sd_addr     <= '0;
      sd_ren      <= 1'b0;
      ren_last    <= 1'b0;
      done        <= 1'b0;
    end else begin
      sd_set_addr <= 1'b0;
      sd_addr     <= '0;
      done        <= 1'b0;
      sd_ren      <= issue;
      ren_last    <= last_issue;
      if (issue) begin
        remaining <= remaining - SD_REMAIN_W'(1);
      end
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            remaining <= SD_REMAIN_W'(req_count) * SD_REMAIN_W'(WORDS_PER_BLOCK);
            if (req_count == '0) begin
              state <= ST_DRAIN;
            end else begin
              state       <= ST_SETADDR;
              sd_set_addr <= 1'b1;
              sd_addr     <= sector_to_addr(req_sector);
            end
          end
        end
        ST_SETADDR: state <= ST_STREAM;
        ST_STREAM: begin
          if (sd_ren && ren_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (done) begin
            state <= ST_IDLE;
          end else if (drained) begin
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sd_word_fifo #(
    .WIDTH(SD_WORD_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (sd_ren),
    .push_data({ren_last, sd_data}),
    .pop      (pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader with a behavioural SD helper model.
module tb_sd_block_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] req_sector = '0;
  logic [7:0]  req_count = '0;
  logic        req_ready, sd_set_addr, sd_ren, out_valid, out_last, busy, done;
  logic [31:0] sd_addr, sd_data, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sd_block_reader #(
    .WORDS_PER_BLOCK(128),
    .FIFO_DEPTH(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sector (req_sector),
    .req_count  (req_count),
    .sd_set_addr(sd_set_addr),
    .sd_addr    (sd_addr),
    .sd_ren     (sd_ren),
    .sd_data    (sd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Helper model: word pointer loaded by the address strobe, bumped per read strobe.
  logic [31:0] hptr = '0;
  always @(posedge clock) begin
    if (sd_set_addr) hptr <= sd_addr >> 2;
    else if (sd_ren) hptr <= hptr + 32'd1;
  end
  assign sd_data = hptr ^ 32'h5A5A_0000;

  // Event recorder sampled mid-cycle.
  int cyc = 0;
  int hs_cyc, set_cyc, first_ren_cyc, first_valid_cyc, last_cyc, done_cyc, rdy_cyc;
  int ren_cnt, pop_cnt, set_cnt, last_cnt, done_cnt, max_occ, occ;
  bit hs_flag, rdy_prev;
  logic [31:0] set_addr_seen;
  logic [32:0] got[$];
  logic [32:0] exp[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    occ = ren_cnt + (sd_ren ? 1 : 0) - pop_cnt;
    if (occ > max_occ) max_occ = occ;
    if (req_valid && req_ready) begin hs_flag = 1'b1; hs_cyc = cyc; end
    if (sd_set_addr) begin set_cnt++; set_addr_seen = sd_addr; set_cyc = cyc; end
    if (sd_ren) begin if (ren_cnt == 0) first_ren_cyc = cyc; ren_cnt++; end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      got.push_back({out_last, out_data});
      pop_cnt++;
      if (out_last) begin last_cnt++; last_cyc = cyc; end
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (req_ready && !rdy_prev) rdy_cyc = cyc;
    rdy_prev = req_ready;
  end

  task automatic clear_mon();
    hs_cyc = 0; set_cyc = 0; first_ren_cyc = 0; first_valid_cyc = -1; last_cyc = 0;
    done_cyc = 0; rdy_cyc = 0; ren_cnt = 0; pop_cnt = 0; set_cnt = 0; last_cnt = 0;
    done_cnt = 0; max_occ = 0; hs_flag = 1'b0; set_addr_seen = '0;
    got.delete(); exp.delete();
  endtask

  task automatic add_expected(input logic [31:0] sector, input int nwords);
    logic [31:0] base;
    base = {sector[22:0], 9'b0} >> 2;
    for (int i = 0; i < nwords; i++)
      exp.push_back({(i == nwords - 1), (base + 32'(i)) ^ 32'h5A5A_0000});
  endtask

  task automatic issue_req(input logic [31:0] sector, input logic [7:0] count, input int budget);
    req_sector = sector;
    req_count  = count;
    hs_flag    = 1'b0;
    req_valid  = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clock);
      if (hs_flag) break;
    end
    #1 req_valid = 1'b0;
    checks++;
    if (!hs_flag) begin errors++; $display("FAIL handshake_timeout: accepted %0d required 1", hs_flag); end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int n = 0; n < budget && done_cnt < target; n++) @(negedge clock);
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL done_timeout: done_cnt %0d required %0d", done_cnt, target); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if ({busy, done, sd_set_addr, sd_ren, out_valid, out_last} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {busy, done, sd_set_addr, sd_ren, out_valid, out_last}); end
    checks++; if (sd_addr !== 32'h0) begin errors++; $display("FAIL reset_sd_addr: got %h want 0", sd_addr); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_single_block();
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b1;
    issue_req(32'd5, 8'd1, 20);
    wait_done(1, 400);
    repeat (2) @(negedge clock);
    add_expected(32'd5, 128);
    checks++; if (set_cnt !== 1) begin errors++; $display("FAIL single_set_cnt: got %0d want 1", set_cnt); end
    checks++; if (set_addr_seen !== 32'h0000_0A00) begin errors++; $display("FAIL single_sd_addr: got %h want 00000a00", set_addr_seen); end
    checks++; if (set_cyc - hs_cyc !== 1) begin errors++; $display("FAIL single_set_cycle: got %0d want 1", set_cyc - hs_cyc); end
    checks++; if (first_ren_cyc - hs_cyc !== 2) begin errors++; $display("FAIL single_first_ren: got %0d want 2", first_ren_cyc - hs_cyc); end
    checks++; if (first_valid_cyc - hs_cyc !== 3) begin errors++; $display("FAIL single_first_valid: got %0d want 3", first_valid_cyc - hs_cyc); end
    checks++; if (ren_cnt !== 128) begin errors++; $display("FAIL single_ren_cnt: got %0d want 128", ren_cnt); end
    checks++; if (got.size() !== 128) begin errors++; $display("FAIL single_word_cnt: got %0d want 128", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL single_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, exp[i]); end
    end
    checks++; if (last_cnt !== 1) begin errors++; $display("FAIL single_last_cnt: got %0d want 1", last_cnt); end
    checks++; if (last_cyc - hs_cyc !== 130) begin errors++; $display("FAIL single_last_cycle: got %0d want 130", last_cyc - hs_cyc); end
    checks++; if (done_cyc - hs_cyc !== 131) begin errors++; $display("FAIL single_done_cycle: got %0d want 131", done_cyc - hs_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rdy_cyc - hs_cyc !== 132) begin errors++; $display("FAIL single_ready_cycle: got %0d want 132", rdy_cyc - hs_cyc); end
  endtask

  task automatic test_zero_count();
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b1;
    issue_req(32'd5, 8'd0, 20);
    wait_done(1, 20);
    repeat (3) @(negedge clock);
    checks++; if (set_cnt !== 0) begin errors++; $display("FAIL zero_set_cnt: got %0d want 0", set_cnt); end
    checks++; if (ren_cnt !== 0) begin errors++; $display("FAIL zero_ren_cnt: got %0d want 0", ren_cnt); end
    checks++; if (first_valid_cyc !== -1) begin errors++; $display("FAIL zero_out_valid: got cycle %0d want none", first_valid_cyc); end
    checks++; if (done_cyc - hs_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc - hs_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rdy_cyc - hs_cyc !== 3) begin errors++; $display("FAIL zero_ready_cycle: got %0d want 3", rdy_cyc - hs_cyc); end
  endtask

  task automatic test_backpressure();
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b0;
    issue_req(32'hFF80_0003, 8'd2, 20);
    for (int k = 0; k < 3000 && done_cnt < 1; k++) begin
      @(posedge clock); #1 out_ready = (k % 3 == 0);
    end
    wait_done(1, 10);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    add_expected(32'hFF80_0003, 256);
    checks++; if (set_addr_seen !== 32'h0000_0600) begin errors++; $display("FAIL bp_sd_addr: got %h want 00000600", set_addr_seen); end
    checks++; if (ren_cnt !== 256) begin errors++; $display("FAIL bp_ren_cnt: got %0d want 256", ren_cnt); end
    checks++; if (got.size() !== 256) begin errors++; $display("FAIL bp_word_cnt: got %0d want 256", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL bp_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, exp[i]); end
    end
    checks++; if (last_cnt !== 1) begin errors++; $display("FAIL bp_last_cnt: got %0d want 1", last_cnt); end
    checks++; if (max_occ > 4) begin errors++; $display("FAIL bp_occupancy: got %0d want <=4", max_occ); end
  endtask

  task automatic test_stall();
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b0;
    issue_req(32'd7, 8'd1, 20);
    repeat (50) @(posedge clock);
    #1;
    checks++; if (ren_cnt !== 4) begin errors++; $display("FAIL stall_ren_cnt: got %0d want 4", ren_cnt); end
    checks++; if (max_occ !== 4) begin errors++; $display("FAIL stall_occupancy: got %0d want 4", max_occ); end
    checks++; if (pop_cnt !== 0) begin errors++; $display("FAIL stall_pop_cnt: got %0d want 0", pop_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    out_ready = 1'b1;
    wait_done(1, 400);
    repeat (2) @(negedge clock);
    add_expected(32'd7, 128);
    checks++; if (ren_cnt !== 128) begin errors++; $display("FAIL stall_ren_total: got %0d want 128", ren_cnt); end
    checks++; if (got.size() !== 128) begin errors++; $display("FAIL stall_word_cnt: got %0d want 128", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL stall_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int hs_a;
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b1;
    issue_req(32'd2, 8'd1, 20);
    hs_a = hs_cyc;
    issue_req(32'd9, 8'd1, 400);
    checks++; if (hs_cyc - hs_a !== 132) begin errors++; $display("FAIL b2b_accept_cycle: got %0d want 132", hs_cyc - hs_a); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_before_accept: got %0d want 1", done_cnt); end
    wait_done(2, 400);
    repeat (2) @(negedge clock);
    add_expected(32'd2, 128);
    add_expected(32'd9, 128);
    checks++; if (set_cnt !== 2) begin errors++; $display("FAIL b2b_set_cnt: got %0d want 2", set_cnt); end
    checks++; if (set_addr_seen !== 32'h0000_1200) begin errors++; $display("FAIL b2b_sd_addr: got %h want 00001200", set_addr_seen); end
    checks++; if (last_cnt !== 2) begin errors++; $display("FAIL b2b_last_cnt: got %0d want 2", last_cnt); end
    checks++; if (got.size() !== 256) begin errors++; $display("FAIL b2b_word_cnt: got %0d want 256", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_stream();
    int dn;
    @(posedge clock); #1;
    clear_mon(); out_ready = 1'b1;
    issue_req(32'd3, 8'd1, 20);
    for (int n = 0; n < 300 && pop_cnt < 40; n++) @(posedge clock);
    checks++; if (pop_cnt < 40) begin errors++; $display("FAIL mid_reach_word40: got %0d want 40", pop_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, sd_set_addr, sd_ren, out_valid, out_last} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_flags: got %b want 000000", {busy, done, sd_set_addr, sd_ren, out_valid, out_last}); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_reset_out_data: got %h want 0", out_data); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_req_ready: got %b want 1", req_ready); end
    dn = done_cnt;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if (done_cnt !== dn) begin errors++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, dn); end
    @(posedge clock); #1;
    clear_mon();
    issue_req(32'd11, 8'd1, 20);
    wait_done(1, 400);
    repeat (2) @(negedge clock);
    add_expected(32'd11, 128);
    checks++; if (set_addr_seen !== 32'h0000_1600) begin errors++; $display("FAIL mid_next_sd_addr: got %h want 00001600", set_addr_seen); end
    checks++; if (done_cyc - hs_cyc !== 131) begin errors++; $display("FAIL mid_next_done_cycle: got %0d want 131", done_cyc - hs_cyc); end
    checks++; if (got.size() !== 128) begin errors++; $display("FAIL mid_next_word_cnt: got %0d want 128", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL mid_next_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, exp[i]); end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_block();
    test_zero_count();
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
